// File: rtl/microwave_countdown.sv
// Countdown engine for the microwave timer: counts a BCD M:TU value down once per
// second, drives the heater enable and handles pause, cancel, door interlock and beep.
module microwave_countdown #(
   parameter int TICKS_PER_SEC = 100_000_000,
   parameter int BEEP_SECONDS  = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       stop,
   input  logic       door_open,
   input  logic [3:0] load_minutes,
   input  logic [3:0] load_tens,
   input  logic [3:0] load_units,
   output logic [3:0] cur_minutes,
   output logic [3:0] cur_tens,
   output logic [3:0] cur_units,
   output logic       running,
   output logic       done,
   output logic       beep
);

   localparam int BEEP_CYCLES = BEEP_SECONDS * TICKS_PER_SEC;
   localparam int PW = $clog2(TICKS_PER_SEC);
   localparam int BW = $clog2(BEEP_CYCLES);
   localparam logic [PW-1:0] TICK_LAST = PW'(TICKS_PER_SEC - 1);
   localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t          state_r;
   logic [PW-1:0]   presc_r;
   logic [BW-1:0]   beep_cnt_r;
   logic            load_ok_s;
   logic [11:0]     next_val_s;

   // One-second BCD decrement with borrow from units into tens and tens into minutes.
   function automatic logic [11:0] bcd_dec(input logic [11:0] v);
      logic [3:0] m;
      logic [3:0] t;
      logic [3:0] u;
      m = v[11:8];
      t = v[7:4];
      u = v[3:0];
      if (u != 4'd0) begin
         u = u - 4'd1;
      end else begin
         u = 4'd9;
         if (t != 4'd0) begin
            t = t - 4'd1;
         end else begin
            t = 4'd5;
            m = m - 4'd1;
         end
      end
      return {m, t, u};
   endfunction

   // Start qualification and the value the next tick would write.
   always_comb begin
      load_ok_s  = (load_minutes <= 4'd9) && (load_tens <= 4'd5) && (load_units <= 4'd9) &&
                   ({load_minutes, load_tens, load_units} != 12'h000);
      next_val_s = bcd_dec({cur_minutes, cur_tens, cur_units});
   end

   // Countdown state machine with registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= IDLE;
         presc_r     <= {PW{1'b0}};
         beep_cnt_r  <= {BW{1'b0}};
         cur_minutes <= 4'd0;
         cur_tens    <= 4'd0;
         cur_units   <= 4'd0;
         running     <= 1'b0;
         done        <= 1'b0;
         beep        <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_r)
            IDLE: begin
               cur_minutes <= load_minutes;
               cur_tens    <= load_tens;
               cur_units   <= load_units;
               running     <= 1'b0;
               beep        <= 1'b0;
               if (!door_open && !stop && start && load_ok_s) begin
                  state_r <= RUN;
                  presc_r <= {PW{1'b0}};
                  running <= 1'b1;
               end else begin
                  state_r <= IDLE;
               end
            end
            RUN: begin
               // A pause request wins over a tick in the same cycle; the prescaler holds.
               if (door_open || stop) begin
                  state_r <= PAUSE;
                  running <= 1'b0;
               end else if (presc_r == TICK_LAST) begin
                  presc_r     <= {PW{1'b0}};
                  cur_minutes <= next_val_s[11:8];
                  cur_tens    <= next_val_s[7:4];
                  cur_units   <= next_val_s[3:0];
                  if (next_val_s == 12'h000) begin
                     state_r    <= DONE;
                     running    <= 1'b0;
                     done       <= 1'b1;
                     beep       <= 1'b1;
                     beep_cnt_r <= {BW{1'b0}};
                  end else begin
                     state_r <= RUN;
                  end
               end else begin
                  presc_r <= presc_r + PW'(1'b1);
               end
            end
            PAUSE: begin
               if (door_open) begin
                  state_r <= PAUSE;
               end else if (stop) begin
                  state_r <= IDLE;
               end else if (start) begin
                  state_r <= RUN;
                  running <= 1'b1;
               end else begin
                  state_r <= PAUSE;
               end
            end
            DONE: begin
               if (stop || (beep_cnt_r == BEEP_LAST)) begin
                  state_r <= IDLE;
                  beep    <= 1'b0;
               end else begin
                  beep_cnt_r <= beep_cnt_r + BW'(1'b1);
               end
            end
            default: begin
               state_r <= IDLE;
               running <= 1'b0;
               beep    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/microwave_countdown.md
# microwave_countdown

Countdown engine for the microwave timer. It takes the three BCD digits produced by the timer-input stage (units of minutes, tens of seconds, units of seconds) and, on start, counts them down once per second. It drives the heater enable and the displayed digits, handles pause, cancel and door-open interlock, and signals completion with a done pulse and a timed beep.

## Interface
Parameters:
- TICKS_PER_SEC, default 100_000_000: clk cycles per second; must be ≥ 2.
- BEEP_SECONDS, default 3: seconds `beep` stays high after completion; must be ≥ 1.

Ports:
- clk  in  1  system clock; the block runs entirely on this one clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to start or resume.
- stop  in  1  single-cycle request to pause, cancel or silence.
- door_open  in  1  level; high means the door is open.
- load_minutes  in  4  BCD minutes digit from the timer input, 0–9.
- load_tens  in  4  BCD tens-of-seconds digit, 0–5.
- load_units  in  4  BCD units-of-seconds digit, 0–9.
- cur_minutes  out  4  displayed minutes digit.
- cur_tens  out  4  displayed tens-of-seconds digit.
- cur_units  out  4  displayed units-of-seconds digit.
- running  out  1  heater enable; high only in RUN.
- done  out  1  one-cycle pulse on completion.
- beep  out  1  high for the whole of DONE.

## Operation
- Reset (rst low) applies immediately, without a clock edge:
  - state goes to IDLE;
  - all cur_* are 0;
  - running, done and beep are 0;
  - the prescaler and beep counter are 0.
- States: IDLE, RUN, PAUSE, DONE. All outputs are registered.
- Input priority within a cycle: door_open > stop > start.
- IDLE:
  - cur_* register load_* every cycle, giving a one-cycle preview latency.
  - start moves to RUN and clears the prescaler, provided all of the following hold:
    - door_open is low;
    - the load digits are valid (minutes ≤ 9, tens ≤ 5, units ≤ 9);
    - the load value is non-zero.
  - The digits latched at that edge are the load_* values on that cycle.
  - Otherwise start is ignored.
- RUN:
  - The prescaler counts 0 to TICKS_PER_SEC−1 and wraps. The tick is the cycle where it equals TICKS_PER_SEC−1.
  - On a tick the BCD value decrements:
    - units 0 borrows: units becomes 9, tens decrements;
    - tens 0 borrows: tens becomes 5, minutes decrements.
  - A tick that would take the value from 0:01 to 0:00 writes 0:00 and moves to DONE on the same edge.
  - door_open or stop moves to PAUSE. The prescaler holds its value, and a tick in that same cycle is discarded.
- PAUSE:
  - Digits and prescaler are frozen.
  - start with door_open low returns to RUN, and the prescaler resumes from its held value.
  - stop moves to IDLE, which cancels the cook.
  - A start while door_open is high is ignored.
- DONE:
  - beep is 1 and the beep counter counts BEEP_SECONDS × TICKS_PER_SEC cycles, then the state goes to IDLE.
  - stop goes to IDLE immediately.
  - start and door_open are ignored.
  - cur_* hold 0:00.
- Reset asserted mid-operation aborts the cook with no done pulse.

## Timing
- start accepted at edge N:
  - running is 1 after edge N;
  - the first decrement occurs at edge N + TICKS_PER_SEC.
- A value of M:TU takes (60·M + 10·T + U) × TICKS_PER_SEC cycles from start to DONE, with no pauses.
- done is high for exactly the one cycle following the edge that writes 0:00. running falls at that same edge.
- Stop or door open in RUN drops running at the next edge. Worst-case latency is one cycle.
- beep rises with done and falls BEEP_SECONDS × TICKS_PER_SEC cycles later, or one cycle after stop.
- IDLE preview: a change on load_* appears on cur_* after one edge.

## Test plan
All scenarios use TICKS_PER_SEC=4 and BEEP_SECONDS=2.
- Reset: hold rst low for 3 cycles with arbitrary inputs -> all outputs 0. Load 1:23 and wait one edge after release -> cur = 1:23, running 0.
- Basic cook: load 0:12, pulse start -> running 1 next cycle; cur 0:11 after 4 cycles. After 48 cycles: cur 0:00, done pulses 1 cycle, beep high 8 cycles, then IDLE with running 0.
- Borrow: load 1:00, start -> cur 0:59 after 4 cycles. Load 0:10, start -> cur 0:09 after 4 cycles.
- Interlock:
  - Raise door_open during RUN at 0:05 -> running 0 next edge; cur stays 0:05 for 20 cycles.
  - Start with the door open -> ignored.
  - Close the door and start -> running resumes; the next decrement arrives after the remaining prescaler count.
  - stop in PAUSE -> IDLE.
- Invalid load: start with 0:00, 0:60 (tens=6) or units=10 -> state stays IDLE, running 0, done 0.
- Async reset mid-cook: assert rst between clock edges at 0:07 -> outputs go to 0 before the next edge; no done pulse.
